// File: rtl/d_mem_axi_bridge.sv
// Bridges the L2 data cache single-word memory port onto an AXI4 single-beat master.
// Latency: 3 cycles strobe-to-m_ready at zero wait; one outstanding request, all outputs registered.
module d_mem_axi_bridge #(
  parameter int A_WIDTH = 32
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic [A_WIDTH-1:0] m_a,
  input  logic [31:0]        m_din,
  output logic [31:0]        m_dout,
  input  logic               m_strobe,
  input  logic [3:0]         m_wen,
  input  logic [1:0]         m_size,
  input  logic               m_rw,
  output logic               m_ready,
  output logic [A_WIDTH-1:0] araddr,
  output logic [2:0]         arsize,
  output logic               arvalid,
  input  logic               arready,
  input  logic [31:0]        rdata,
  input  logic [1:0]         rresp,
  input  logic               rvalid,
  output logic               rready,
  output logic [A_WIDTH-1:0] awaddr,
  output logic [2:0]         awsize,
  output logic               awvalid,
  input  logic               awready,
  output logic [31:0]        wdata,
  output logic [3:0]         wstrb,
  output logic               wvalid,
  input  logic               wready,
  input  logic [1:0]         bresp,
  input  logic               bvalid,
  output logic               bready
);

  typedef enum logic [2:0] {IDLE, RD_AR, RD_R, WR_AWW, WR_B, DONE} state_t;

  state_t               state_q, state_d;
  logic [A_WIDTH-1:0]   addr_q, addr_d;
  logic [31:0]          din_q, din_d;
  logic [31:0]          dout_q, dout_d;
  logic [3:0]           wen_q, wen_d;
  logic [1:0]           size_q, size_d;
  logic                 arvalid_q, arvalid_d;
  logic                 rready_q, rready_d;
  logic                 awvalid_q, awvalid_d;
  logic                 wvalid_q, wvalid_d;
  logic                 bready_q, bready_d;
  logic                 aw_done_q, aw_done_d;
  logic                 w_done_q, w_done_d;
  logic                 m_ready_q, m_ready_d;

  // Response codes carry no meaning for the cache; any response completes the access.
  logic unused_resp;
  assign unused_resp = ^{rresp, bresp};

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    din_d     = din_q;
    dout_d    = dout_q;
    wen_d     = wen_q;
    size_d    = size_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    m_ready_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (m_strobe) begin
          addr_d = m_a;
          din_d  = m_din;
          wen_d  = m_wen;
          size_d = m_size;
          if (m_rw) begin
            state_d   = WR_AWW;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end else begin
            state_d   = RD_AR;
            arvalid_d = 1'b1;
          end
        end
      end
      RD_AR: begin
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_R;
        end
      end
      RD_R: begin
        if (rvalid) begin
          dout_d    = rdata;
          rready_d  = 1'b0;
          m_ready_d = 1'b1;
          state_d   = DONE;
        end
      end
      WR_AWW: begin
        // AW and W complete independently, in either order or together.
        if (awvalid_q && awready) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (wvalid_q && wready) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if (aw_done_d && w_done_d) begin
          bready_d = 1'b1;
          state_d  = WR_B;
        end
      end
      WR_B: begin
        if (bvalid) begin
          bready_d  = 1'b0;
          m_ready_d = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        // Strobe is still high here; skipping it avoids reissuing the same request.
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        bready_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      din_q     <= '0;
      dout_q    <= '0;
      wen_q     <= '0;
      size_q    <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      m_ready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      dout_q    <= dout_d;
      wen_q     <= wen_d;
      size_q    <= size_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      m_ready_q <= m_ready_d;
    end
  end

  assign m_dout  = dout_q;
  assign m_ready = m_ready_q;
  assign araddr  = addr_q;
  assign arsize  = {1'b0, size_q};
  assign arvalid = arvalid_q;
  assign rready  = rready_q;
  assign awaddr  = addr_q;
  assign awsize  = {1'b0, size_q};
  assign awvalid = awvalid_q;
  assign wdata   = din_q;
  assign wstrb   = wen_q;
  assign wvalid  = wvalid_q;
  assign bready  = bready_q;

endmodule

// File: tb/tb_d_mem_axi_bridge.sv
// Directed bench for d_mem_axi_bridge: AXI slave model with per-channel delays and a request scoreboard.
module tb_d_mem_axi_bridge;

  logic        clk = 1'b0;
  logic        clrn;
  logic [31:0] m_a, m_din, m_dout;
  logic        m_strobe, m_rw, m_ready;
  logic [3:0]  m_wen;
  logic [1:0]  m_size;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [2:0]  arsize, awsize;
  logic        arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready, bvalid, bready;
  logic [1:0]  rresp, bresp;
  logic [3:0]  wstrb;

  always #5 clk = ~clk;

  d_mem_axi_bridge #(.A_WIDTH(32)) dut (
    .clk(clk), .clrn(clrn), .m_a(m_a), .m_din(m_din), .m_dout(m_dout), .m_strobe(m_strobe),
    .m_wen(m_wen), .m_size(m_size), .m_rw(m_rw), .m_ready(m_ready),
    .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  typedef struct {
    bit          rw;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  size;
    logic [31:0] dout;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0, n_err = 0;
  int   ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
  int   n_ar = 0, n_aw = 0, n_w = 0, n_b = 0, n_done = 0;
  int   exp_ar = 0, exp_aw = 0, exp_done = 0;
  logic [31:0] slave_rdata = '0;
  logic [31:0] last_read = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Slave model: inputs change on negedge; hs flags mark handshakes landing on the next posedge.
  initial begin : slave
    int ar_wait, r_wait, aw_wait, w_wait, b_wait;
    bit pend_r, pend_b, aw_got, w_got;
    bit ar_hs, r_hs, aw_hs, w_hs, b_hs;
    bit p_arv, p_awv, p_wv, p_mrdy;
    logic [31:0] p_araddr, p_awaddr, p_wdata;
    exp_t e;
    arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
    rdata = '0; rresp = 2'b10; bresp = 2'b11;
    forever begin
      @(negedge clk);
      if (clrn !== 1'b1) begin
        ar_wait = 0; r_wait = 0; aw_wait = 0; w_wait = 0; b_wait = 0;
        pend_r = 0; pend_b = 0; aw_got = 0; w_got = 0;
        ar_hs = 0; r_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0;
        p_arv = 0; p_awv = 0; p_wv = 0; p_mrdy = 0;
        arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
        continue;
      end
      if (ar_hs) begin chk("arvalid_drop", arvalid, 0); pend_r = 1; r_wait = 0; end
      else if (p_arv) begin chk("arvalid_hold", arvalid, 1); chk("araddr_hold", araddr, p_araddr); end
      if (aw_hs) begin chk("awvalid_drop", awvalid, 0); aw_got = 1; end
      else if (p_awv) begin chk("awvalid_hold", awvalid, 1); chk("awaddr_hold", awaddr, p_awaddr); end
      if (w_hs) begin chk("wvalid_drop", wvalid, 0); w_got = 1; end
      else if (p_wv) begin chk("wvalid_hold", wvalid, 1); chk("wdata_hold", wdata, p_wdata); end
      if (r_hs) rvalid = 0;
      if (b_hs) bvalid = 0;
      if (aw_got && w_got) begin pend_b = 1; b_wait = 0; aw_got = 0; w_got = 0; end

      arready = arvalid && (ar_wait >= ar_delay);
      if (arvalid && !arready) ar_wait++;
      awready = awvalid && (aw_wait >= aw_delay);
      if (awvalid && !awready) aw_wait++;
      wready = wvalid && (w_wait >= w_delay);
      if (wvalid && !wready) w_wait++;
      if (pend_r && !rvalid) begin
        if (r_wait >= r_delay) begin rvalid = 1; rdata = slave_rdata; end
        else r_wait++;
      end
      if (pend_b && !bvalid) begin
        if (b_wait >= b_delay) bvalid = 1;
        else b_wait++;
      end

      ar_hs = arvalid && arready;
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      r_hs  = rvalid && rready;
      b_hs  = bvalid && bready;
      if (ar_hs) begin
        n_ar++; ar_wait = 0;
        if (exp_q.size() > 0) begin
          chk("ar_addr", araddr, exp_q[0].addr);
          chk("ar_size", {29'd0, arsize}, {30'd0, exp_q[0].size});
        end
      end
      if (aw_hs) begin
        n_aw++; aw_wait = 0;
        if (exp_q.size() > 0) begin
          chk("aw_addr", awaddr, exp_q[0].addr);
          chk("aw_size", {29'd0, awsize}, {30'd0, exp_q[0].size});
        end
      end
      if (w_hs) begin
        n_w++; w_wait = 0;
        if (exp_q.size() > 0) begin
          chk("w_data", wdata, exp_q[0].data);
          chk("w_strb", {28'd0, wstrb}, {28'd0, exp_q[0].strb});
        end
      end
      if (r_hs) pend_r = 0;
      if (b_hs) begin pend_b = 0; n_b++; end

      if (m_ready) begin
        chk("m_ready_pulse", {31'd0, p_mrdy}, 0);
        n_done++;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("m_dout", m_dout, e.dout);
        end else begin
          chk("m_ready_stale", {31'd0, m_ready}, 0);
        end
      end
      p_mrdy = m_ready;
      p_arv = arvalid && !ar_hs;  p_araddr = araddr;
      p_awv = awvalid && !aw_hs;  p_awaddr = awaddr;
      p_wv  = wvalid && !w_hs;    p_wdata  = wdata;
    end
  end

  task automatic issue(input bit rw, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] en, input logic [1:0] sz, input logic [31:0] rd);
    exp_t e;
    e.rw = rw; e.addr = a; e.data = d; e.strb = en; e.size = sz;
    if (rw) begin
      e.dout = last_read; exp_aw++;
    end else begin
      e.dout = rd; last_read = rd; slave_rdata = rd; exp_ar++;
    end
    exp_done++;
    exp_q.push_back(e);
    m_a = a; m_din = d; m_wen = en; m_size = sz; m_rw = rw; m_strobe = 1'b1;
  endtask

  task automatic wait_done(output int lat);
    bit got = 0;
    lat = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      lat++;
      got = m_ready;
    end
    chk("req_timeout", {31'd0, got}, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valids"}, {26'd0, arvalid, rready, awvalid, wvalid, bready, m_ready}, 0);
    chk({tag, "_dout"}, m_dout, 0);
    chk({tag, "_regs"}, araddr | awaddr | wdata | {28'd0, wstrb} | {29'd0, arsize}, 0);
  endtask

  initial begin : stim
    int lat;
    bit seen;
    clrn = 1'b0; m_a = '0; m_din = '0; m_wen = '0; m_size = '0; m_rw = 1'b0; m_strobe = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    clrn = 1'b1;
    @(negedge clk);

    // Zero-wait word read.
    issue(0, 32'h0000_1000, 32'h0, 4'h0, 2'd2, 32'hDEADBEEF);
    wait_done(lat);
    chk("rd_latency", lat, 3);
    m_strobe = 1'b0;
    repeat (2) @(negedge clk);

    // Zero-wait halfword write; m_dout keeps the last read data.
    issue(1, 32'h0000_2004, 32'h12345678, 4'b0011, 2'd1, 32'h0);
    wait_done(lat);
    chk("wr_latency", lat, 3);
    m_strobe = 1'b0;
    @(negedge clk);

    // W delayed, then AW delayed.
    w_delay = 3;
    issue(1, 32'h0000_2100, 32'hA5A5_0001, 4'b1111, 2'd2, 32'h0);
    wait_done(lat);
    chk("wr_wdelay_latency", lat, 6);
    m_strobe = 1'b0;
    @(negedge clk);
    w_delay = 0; aw_delay = 3; b_delay = 2;
    issue(1, 32'h0000_2200, 32'h5A5A_0002, 4'b1100, 2'd2, 32'h0);
    wait_done(lat);
    chk("wr_awdelay_latency", lat, 8);
    m_strobe = 1'b0;
    aw_delay = 0; b_delay = 0;
    @(negedge clk);

    // Writeback then refill with strobe held high across the boundary.
    issue(1, 32'h0000_3000, 32'h0BAD_F00D, 4'b1111, 2'd2, 32'h0);
    wait_done(lat);
    issue(0, 32'h0000_7000, 32'h0, 4'h0, 2'd2, 32'h1357_9BDF);
    wait_done(lat);
    chk("b2b_rd_latency", lat, 4);
    m_strobe = 1'b0;
    repeat (3) @(negedge clk);

    // AR and R stalls.
    ar_delay = 5; r_delay = 4;
    issue(0, 32'h0000_8000, 32'h0, 4'h0, 2'd0, 32'h0000_00AB);
    wait_done(lat);
    chk("stall_latency", lat, 12);
    m_strobe = 1'b0;
    ar_delay = 0; r_delay = 20;
    @(negedge clk);

    // Reset while waiting on R, then a fresh read.
    issue(0, 32'h0000_9000, 32'h0, 4'h0, 2'd2, 32'hFFFF_0000);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = rready;
    end
    chk("rd_r_reached", {31'd0, seen}, 1);
    repeat (2) @(negedge clk);
    clrn = 1'b0;
    m_strobe = 1'b0;
    #1;
    check_reset_outputs("midrst");
    exp_q.delete();
    exp_done--;
    last_read = '0;
    r_delay = 0;
    repeat (2) @(negedge clk);
    clrn = 1'b1;
    repeat (4) @(negedge clk);
    issue(0, 32'h0000_A000, 32'h0, 4'h0, 2'd2, 32'hCAFE_F00D);
    wait_done(lat);
    chk("post_rst_latency", lat, 3);
    m_strobe = 1'b0;
    repeat (4) @(negedge clk);

    chk("count_ar", n_ar, exp_ar);
    chk("count_aw", n_aw, exp_aw);
    chk("count_w", n_w, exp_aw);
    chk("count_b", n_b, exp_aw);
    chk("count_done", n_done, exp_done);
    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
